// File: rtl/kp_adapt_if.sv
// kp_adapt_if: handshake bundle between the gain-adaptation loop and its environment.
interface kp_adapt_if;
  logic       en;
  logic       evt;
  logic [7:0] inc;
  logic [3:0] n;
  logic [7:0] kp;
  logic       upd;
  logic       busy;
  modport master (output en, evt, inc, input n, kp, upd, busy);
  modport slave  (input en, evt, inc, output n, kp, upd, busy);
endinterface

// File: rtl/kp_adapt_loop.sv
// kp_adapt_loop: windowed event counter feeding a decision block and saturating kp integrator.
// Define KPA_DEADBAND_EN to hold kp when the window count equals N_TARGET.
module kp_adapt_loop #(
  parameter int         WIN_LEN    = 64,
  parameter int         SETTLE_LEN = 16,
  parameter logic [7:0] KP_INIT    = 8'h40,
  parameter logic [7:0] KP_MIN     = 8'h01,
  parameter logic [7:0] KP_MAX     = 8'hFE,
  parameter int         N_TARGET   = 4
) (
  input logic       clk,
  input logic       rst_n,
  kp_adapt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEAS, UPD, SETTLE} state_t;
  localparam int CW = $clog2(WIN_LEN > SETTLE_LEN ? WIN_LEN : SETTLE_LEN);
  localparam logic [7:0] KP_RST = KP_INIT < KP_MIN ? KP_MIN : KP_INIT > KP_MAX ? KP_MAX : KP_INIT;
`ifdef KPA_DEADBAND_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] ev_q, ev_d, ev_inc, n_q, n_d;
  logic [7:0] kp_q, kp_d;
  logic upd_q, upd_d;
  logic signed [9:0] sum;
  logic hold;
  always_comb begin
    ev_inc = (bus.evt && ev_q != 4'hF) ? ev_q + 4'd1 : ev_q;
    sum = $signed({2'b00, kp_q}) + $signed({{2{bus.inc[7]}}, bus.inc});
    hold = DB && n_q == 4'(N_TARGET);
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    ev_d = ev_q;
    n_d = n_q;
    kp_d = kp_q;
    upd_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        ev_d = '0;
        state_d = bus.en ? MEAS : IDLE;
      end
      MEAS: begin
        ev_d = ev_inc;
        if (cnt_q == CW'(WIN_LEN - 1)) begin
          n_d = ev_inc;
          state_d = UPD;
        end
      end
      UPD: begin
        upd_d = 1'b1;
        kp_d = hold ? kp_q
             : sum < $signed({2'b00, KP_MIN}) ? KP_MIN
             : sum > $signed({2'b00, KP_MAX}) ? KP_MAX : sum[7:0];
        cnt_d = '0;
        state_d = SETTLE;
      end
      default: if (cnt_q == CW'(SETTLE_LEN - 1)) begin
        cnt_d = '0;
        ev_d = '0;
        state_d = MEAS;
      end
    endcase
    // Dropping en abandons a partial window but lets an in-flight kp update land.
    if (!bus.en && state_q != IDLE) begin
      state_d = IDLE;
      n_d = n_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ev_q <= '0;
      n_q <= '0;
      kp_q <= KP_RST;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ev_q <= ev_d;
      n_q <= n_d;
      kp_q <= kp_d;
      upd_q <= upd_d;
    end
  assign bus.n = n_q;
  assign bus.kp = kp_q;
  assign bus.upd = upd_q;
  assign bus.busy = state_q != IDLE;
endmodule
